tl_sram_responder: RTL and testbench
====================================

# tl_sram_responder

TileLink-UL responder (slave) terminating the A channel and producing D-channel responses from a small internal word-addressed SRAM. It sits at the far end of the TileLink fabric, behind the FIFO fixer and crossbar, and serves as a scratchpad or test target. It answers strictly in request order, which satisfies the FIFO ordering the upstream fixer relies on. Only single-beat transfers are supported, with a 64-bit data bus.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 64-bit words; power of two, at least 2.
- BASE_ADDR, 29'h0, byte base address; aligned to DEPTH_WORDS*8.
- QUEUE_DEPTH, 2, response-queue entries; at least 1.

Ports:
- clock  in  1  single clock.
- reset  in  1  reset, synchronous, active-high.
- auto_in_a_valid  in  1  request valid.
- auto_in_a_ready  out  1  request accepted when high together with valid.
- auto_in_a_bits_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
- auto_in_a_bits_param  in  3  ignored.
- auto_in_a_bits_size  in  3  log2 of the byte count.
- auto_in_a_bits_source  in  7  requester ID.
- auto_in_a_bits_address  in  29  byte address.
- auto_in_a_bits_mask  in  8  byte lanes.
- auto_in_a_bits_data  in  64  write data.
- auto_in_a_bits_corrupt  in  1  when set on a Put, the write is suppressed.
- auto_in_d_valid  out  1  response valid.
- auto_in_d_ready  in  1  response consumed when high together with valid.
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData.
- auto_in_d_bits_size  out  3  echo of the request size.
- auto_in_d_bits_source  out  7  echo of the request source.
- auto_in_d_bits_data  out  64  read data; zero for AccessAck.
- auto_in_d_bits_denied  out  1  the request was rejected.

## Operation
- A request is accepted (a_fire) when valid and ready are both high in a cycle.
- a_ready = !reset && (count < QUEUE_DEPTH). There is no bypass: a full queue blocks A even if D fires in the same cycle.
- Word index = address[3 +: log2(DEPTH_WORDS)].
- The request is in range when address >= BASE_ADDR and address < BASE_ADDR + DEPTH_WORDS*8.
- A request is legal when it is in range, size <= 3, and the opcode is one of {0, 1, 4}.
- Put (0 or 1), legal and not corrupt:
  - On the a_fire edge, each byte lane i is written where mask[i]=1.
  - An AccessAck entry with data 0 and denied 0 is enqueued.
- Put, legal but corrupt: no write; AccessAck with denied 0 is enqueued.
- Get, legal: the full 64-bit word is read on the a_fire edge and an AccessAckData entry is enqueued. The mask does not gate the read.
- Any illegal request: no memory access. The enqueued entry has denied 1 and data 0; its opcode is AccessAckData if the request opcode was 4, otherwise AccessAck.
- Every response echoes the request's size and source.
- D presents the head of the queue. d_valid = (count != 0). The entry is popped on d_fire.
- Responses leave in strict acceptance order.

## Timing
- Reset values:
  - a_ready 0 while reset is high, then 1 on the first cycle after reset.
  - d_valid 0, queue count 0.
  - d_bits: opcode, size, source and data all 0; denied 0.
  - SRAM contents are not reset and are undefined until written.
- Latency: a_fire in cycle N gives d_valid in cycle N+1, when the queue was empty.
- Throughput: 1 request per cycle while d_ready=1, with QUEUE_DEPTH >= 2.
- Read-after-write: a Get accepted in cycle N+1 returns the data of a Put accepted in cycle N.
- d_bits remain stable while d_valid && !d_ready.
- Simultaneous a_fire and d_fire: count is unchanged; the head advances and the tail is written.
- Queue pointers wrap modulo QUEUE_DEPTH, which need not be a power of two.
- Reset asserted mid-operation: all queued responses are dropped, the in-flight A beat is not accepted, and SRAM writes in that cycle are blocked.

## Structure
- Shared package tl_pkg holds:
  - A-opcode constants: PUT_FULL=0, PUT_PARTIAL=1, GET=4.
  - D-opcode constants: ACK=0, ACK_DATA=1.
  - Typedef tl_d_entry_t: {opcode, size, source, data, denied}.
- Sub-module tl_resp_queue: parameterized synchronous FIFO of tl_d_entry_t with full/empty/count outputs.
- The top level holds the decode and legality check, the byte-masked SRAM array (combinational read captured into the queue) and the glue logic.

## Test plan
- Put/Get: PutFull at address 0x18, mask 0xFF, data 0x1122334455667788, source 5; then Get at 0x18, source 9.
  - Expect AccessAck (source 5, denied 0).
  - Then AccessAckData with data 0x1122334455667788, source 9, each response 1 cycle after its a_fire.
- Partial write: PutPartial at 0x18, mask 0x0F, data 0xAAAAAAAA_BBBBBBBB, then Get at 0x18.
  - Expect data 0x11223344_BBBBBBBB.
- Backpressure: hold d_ready=0 and issue 3 Gets back to back.
  - Expect a_ready to drop after 2 accepts.
  - Raising d_ready drains the responses in order by source, with no drop or duplicate.
- Illegal requests: Get at BASE+0x800 (out of range for DEPTH_WORDS=256), then opcode 2, then size 4.
  - Expect AccessAckData/denied=1/data 0, then AccessAck/denied=1, then AccessAck/denied=1.
  - SRAM unchanged.
- Corrupt write: PutFull with corrupt=1 to 0x18.
  - Expect AccessAck with denied 0; a following Get returns the old data.
- Reset mid-operation: queue 2 responses with d_ready=0, then pulse reset for 1 cycle.
  - Expect d_valid 0 and a_ready 0 during reset, a_ready 1 in the next cycle, and no stale responses.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: shared TileLink-UL definitions used by the SRAM responder.
//   - A-channel opcodes: PUT_FULL, PUT_PARTIAL, GET
//   - D-channel opcodes: ACK, ACK_DATA
//   - tl_d_entry_t: one queued D-channel response
//   - is_known_opcode(): true for the A opcodes this responder serves
package tl_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;

  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [6:0]  source;
    logic [63:0] data;
    logic        denied;
  } tl_d_entry_t;

  function automatic logic is_known_opcode(input logic [2:0] op);
    return (op == PUT_FULL) || (op == PUT_PARTIAL) || (op == GET);
  endfunction

endpackage

// File: rtl/tl_resp_queue.sv
// tl_resp_queue: synchronous FIFO of D-channel response entries.
// Ports:
//   clock, reset    - clock and synchronous active-high reset (control only)
//   push/push_entry - enqueue one entry (ignored when full)
//   pop             - dequeue the head entry (ignored when empty)
//   head            - entry at the head of the queue
//   full/empty      - occupancy flags
//   count           - number of entries held
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module tl_resp_queue
  import tl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  tl_d_entry_t                      push_entry,
  input  logic                             pop,
  output tl_d_entry_t                      head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  tl_d_entry_t     store [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   cnt;
  logic            push_ok;
  logic            pop_ok;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
    end else begin
      if (push_ok) tail_ptr <= wrap_inc(tail_ptr);
      if (pop_ok)  head_ptr <= wrap_inc(head_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (push_ok) store[tail_ptr] <= push_entry;
  end

  assign head  = store[head_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/tl_sram_responder.sv
// tl_sram_responder: TileLink-UL single-beat responder backed by a
// word-addressed 64-bit SRAM. Responses return strictly in request order.
// Ports:
//   clock, reset         - clock, synchronous active-high reset
//   auto_in_a_*          - A channel (requests in)
//   auto_in_d_*          - D channel (responses out)
// Requests are decoded and checked for legality on acceptance; Puts update
// the masked byte lanes, Gets capture the combinational read into the
// response queue, and illegal requests produce a denied response.
module tl_sram_responder
  import tl_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [28:0] BASE_ADDR   = 29'h0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [6:0]  auto_in_a_bits_source,
  input  logic [28:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [6:0]  auto_in_d_bits_source,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_denied
);

  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = $clog2(QUEUE_DEPTH + 1);
  localparam logic [29:0] SPAN = 30'(DEPTH_WORDS * 8);

  logic [63:0]  sram [DEPTH_WORDS];
  logic [IW-1:0] word_idx;
  logic [29:0]  offset;
  logic         in_range;
  logic         legal;
  logic         is_get;
  logic         is_put;
  logic         a_fire;
  logic         d_fire;
  logic         do_write;
  tl_d_entry_t  enq_entry;
  tl_d_entry_t  head_entry;
  logic         q_full;
  logic         q_empty;
  logic [CW-1:0] q_count;
  logic         unused_ok;

  // A single subtraction covers both bounds: an address below the base
  // wraps to a value far above SPAN.
  assign offset   = {1'b0, auto_in_a_bits_address} - {1'b0, BASE_ADDR};
  assign in_range = (offset < SPAN);
  assign word_idx = auto_in_a_bits_address[3 +: IW];
  assign is_get   = (auto_in_a_bits_opcode == GET);
  assign is_put   = (auto_in_a_bits_opcode == PUT_FULL) ||
                    (auto_in_a_bits_opcode == PUT_PARTIAL);
  assign legal    = in_range && (auto_in_a_bits_size <= 3'd3) &&
                    is_known_opcode(auto_in_a_bits_opcode);

  // Ready already excludes reset, so no write or enqueue happens in a
  // reset cycle. No bypass: a full queue blocks A even when D drains.
  assign auto_in_a_ready = !reset && !q_full;
  assign a_fire          = auto_in_a_valid && auto_in_a_ready;
  assign do_write        = a_fire && legal && is_put && !auto_in_a_bits_corrupt;

  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 8; i++) begin
        if (auto_in_a_bits_mask[i]) sram[word_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    enq_entry        = '0;
    enq_entry.opcode = is_get ? ACK_DATA : ACK;
    enq_entry.size   = auto_in_a_bits_size;
    enq_entry.source = auto_in_a_bits_source;
    enq_entry.denied = !legal;
    if (legal && is_get) enq_entry.data = sram[word_idx];
  end

  tl_resp_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (a_fire),
    .push_entry (enq_entry),
    .pop        (d_fire),
    .head       (head_entry),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  // D bits are forced to zero whenever nothing is presented, which also
  // gives all-zero outputs during and right after reset.
  assign auto_in_d_valid       = !reset && !q_empty;
  assign d_fire                = auto_in_d_valid && auto_in_d_ready;
  assign auto_in_d_bits_opcode = auto_in_d_valid ? head_entry.opcode : 3'd0;
  assign auto_in_d_bits_size   = auto_in_d_valid ? head_entry.size   : 3'd0;
  assign auto_in_d_bits_source = auto_in_d_valid ? head_entry.source : 7'd0;
  assign auto_in_d_bits_data   = auto_in_d_valid ? head_entry.data   : 64'd0;
  assign auto_in_d_bits_denied = auto_in_d_valid && head_entry.denied;

  assign unused_ok = ^{auto_in_a_bits_param, q_count};

endmodule

// File: tb/tb_tl_sram_responder.sv
// Self-checking bench for tl_sram_responder: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue/array model of the responder.
module tb_tl_sram_responder;

  localparam int DW = 256;
  localparam int QD = 2;

  logic        clock;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [6:0]  a_source;
  logic [28:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic [6:0]  d_source;
  logic [63:0] d_data;
  logic        d_denied;

  tl_sram_responder #(
    .DEPTH_WORDS (DW),
    .BASE_ADDR   (29'h0),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_param   (a_param),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_a_bits_corrupt (a_corrupt),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_data    (d_data),
    .auto_in_d_bits_denied  (d_denied)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [6:0]  src;
    logic [63:0] data;
    logic        den;
  } exp_t;

  exp_t        mq[$];
  logic [63:0] mm [DW];

  // Checks the outputs of the current cycle, then advances the model by the
  // transfers that will happen on the coming rising edge.
  always @(negedge clock) begin
    bit          exp_ready;
    bit          exp_dv;
    bit          lgl;
    int          idx;
    exp_t        e;
    exp_ready = !reset && (mq.size() < QD);
    exp_dv    = !reset && (mq.size() != 0);
    chk("a_ready", a_ready, exp_ready);
    chk("d_valid", d_valid, exp_dv);
    if (exp_dv) begin
      chk("d_opcode", d_opcode, mq[0].op);
      chk("d_size",   d_size,   mq[0].size);
      chk("d_source", d_source, mq[0].src);
      chk("d_data",   d_data,   mq[0].data);
      chk("d_denied", d_denied, mq[0].den);
    end else begin
      chk("d_idle_bits", {d_opcode, d_size, d_source, d_denied}, 0);
      chk("d_idle_data", d_data, 0);
    end
    if (reset) begin
      mq.delete();
    end else begin
      if (exp_dv && d_ready) void'(mq.pop_front());
      if (a_valid && exp_ready) begin
        lgl = (a_address < 29'(DW * 8)) && (a_size <= 3) &&
              (a_opcode == 0 || a_opcode == 1 || a_opcode == 4);
        idx    = int'(a_address) / 8 % DW;
        e.op   = (a_opcode == 4) ? 3'd1 : 3'd0;
        e.size = a_size;
        e.src  = a_source;
        e.den  = !lgl;
        e.data = (lgl && a_opcode == 4) ? mm[idx] : 64'd0;
        if (lgl && a_opcode != 4 && !a_corrupt) begin
          for (int b = 0; b < 8; b++)
            if (a_mask[b]) mm[idx][8*b +: 8] = a_data[8*b +: 8];
        end
        mq.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [28:0] addr, input logic [2:0] size,
                     input logic [6:0] src, input logic [7:0] mask, input logic [63:0] data,
                     input logic corrupt);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_address = addr;
    a_size    = size;
    a_source  = src;
    a_mask    = mask;
    a_data    = data;
    a_corrupt = corrupt;
    a_param   = 3'($urandom);
  endtask

  task automatic expect_d(input string tag, input logic [2:0] op, input logic [2:0] size,
                          input logic [6:0] src, input logic [63:0] data, input logic den);
    @(negedge clock);
    chk({tag, "_valid"},  d_valid,  1'b1);
    chk({tag, "_opcode"}, d_opcode, op);
    chk({tag, "_size"},   d_size,   size);
    chk({tag, "_source"}, d_source, src);
    chk({tag, "_data"},   d_data,   data);
    chk({tag, "_denied"}, d_denied, den);
  endtask

  localparam logic [63:0] V1 = 64'h1122334455667788;
  localparam logic [63:0] V2 = 64'h11223344BBBBBBBB;

  initial begin
    reset = 1'b1; a_valid = 1'b0; d_ready = 1'b1;
    a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; a_corrupt = 0;
    step(); step();
    @(negedge clock);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_bits", {d_opcode, d_size, d_source, d_denied}, 0);
    chk("rst_d_data", d_data, 0);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_a_ready", a_ready, 1);
    step();

    // Put then Get, back to back (read-after-write)
    req(3'd0, 29'h18, 3'd3, 7'd5, 8'hFF, V1, 1'b0);
    step();
    req(3'd4, 29'h18, 3'd3, 7'd9, 8'h00, 64'd0, 1'b0);
    expect_d("put_ack", 3'd0, 3'd3, 7'd5, 64'd0, 1'b0);
    step();
    a_valid = 1'b0;
    expect_d("get_data", 3'd1, 3'd3, 7'd9, V1, 1'b0);
    step();

    // Partial write
    req(3'd1, 29'h18, 3'd3, 7'd6, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0);
    step();
    req(3'd4, 29'h18, 3'd3, 7'd7, 8'hFF, 64'd0, 1'b0);
    expect_d("pput_ack", 3'd0, 3'd3, 7'd6, 64'd0, 1'b0);
    step();
    a_valid = 1'b0;
    expect_d("pget_data", 3'd1, 3'd3, 7'd7, V2, 1'b0);
    step();

    // Backpressure: three Gets with d_ready low
    d_ready = 1'b0;
    req(3'd4, 29'h18, 3'd3, 7'd20, 8'hFF, 64'd0, 1'b0);
    @(negedge clock); chk("bp_ready0", a_ready, 1);
    step(); a_source = 7'd21;
    @(negedge clock); chk("bp_ready1", a_ready, 1);
    step(); a_source = 7'd22;
    @(negedge clock); chk("bp_full", a_ready, 0); chk("bp_head0", d_source, 20);
    step();
    @(negedge clock); chk("bp_hold", a_ready, 0); chk("bp_head_stable", d_source, 20);
    step(); d_ready = 1'b1;
    @(negedge clock); chk("bp_nobypass", a_ready, 0); chk("bp_drain0", d_source, 20);
    step();
    @(negedge clock); chk("bp_ready_again", a_ready, 1); chk("bp_drain1", d_source, 21);
    step(); a_valid = 1'b0;
    expect_d("bp_drain2", 3'd1, 3'd3, 7'd22, V2, 1'b0);
    step();
    @(negedge clock); chk("bp_empty", d_valid, 0);
    step();

    // Illegal requests
    req(3'd4, 29'h800, 3'd3, 7'd40, 8'hFF, 64'd0, 1'b0);
    step();
    req(3'd2, 29'h18, 3'd3, 7'd41, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    expect_d("ill_range", 3'd1, 3'd3, 7'd40, 64'd0, 1'b1);
    step();
    req(3'd0, 29'h18, 3'd4, 7'd42, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    expect_d("ill_opcode", 3'd0, 3'd3, 7'd41, 64'd0, 1'b1);
    step();
    req(3'd4, 29'h18, 3'd3, 7'd43, 8'hFF, 64'd0, 1'b0);
    expect_d("ill_size", 3'd0, 3'd4, 7'd42, 64'd0, 1'b1);
    step();
    a_valid = 1'b0;
    expect_d("ill_unchanged", 3'd1, 3'd3, 7'd43, V2, 1'b0);
    step();

    // Corrupt write
    req(3'd0, 29'h18, 3'd3, 7'd50, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    step();
    req(3'd4, 29'h18, 3'd3, 7'd51, 8'hFF, 64'd0, 1'b0);
    expect_d("corrupt_ack", 3'd0, 3'd3, 7'd50, 64'd0, 1'b0);
    step();
    a_valid = 1'b0;
    expect_d("corrupt_old", 3'd1, 3'd3, 7'd51, V2, 1'b0);
    step();

    // Reset mid-operation with two queued responses and a Put in flight
    d_ready = 1'b0;
    req(3'd4, 29'h18, 3'd3, 7'd60, 8'hFF, 64'd0, 1'b0);
    step(); a_source = 7'd61;
    step();
    req(3'd0, 29'h18, 3'd3, 7'd62, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0);
    reset = 1'b1;
    @(negedge clock); chk("mrst_d_valid", d_valid, 0); chk("mrst_a_ready", a_ready, 0);
    step();
    reset = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    @(negedge clock); chk("mrst_after_ready", a_ready, 1); chk("mrst_no_stale", d_valid, 0);
    step();
    req(3'd4, 29'h18, 3'd3, 7'd63, 8'hFF, 64'd0, 1'b0);
    @(negedge clock); chk("mrst_still_empty", d_valid, 0);
    step();
    a_valid = 1'b0;
    expect_d("mrst_write_blocked", 3'd1, 3'd3, 7'd63, V2, 1'b0);
    step();

    // Fill the whole SRAM so every random Get has a defined result
    for (int i = 0; i < DW; i++) begin
      req(3'd0, 29'(i * 8), 3'd3, 7'(i), 8'hFF, {$urandom, $urandom}, 1'b0);
      step();
    end
    a_valid = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset   = ($urandom_range(0, 299) == 0);
      d_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      req((r < 4) ? 3'd4 : (r < 7) ? 3'd0 : (r < 9) ? 3'd1 : 3'($urandom),
          ($urandom_range(0, 5) == 0) ? 29'($urandom_range(0, 29'h1FFF)) : 29'($urandom_range(0, 29'h7FF)),
          ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3)),
          7'($urandom), 8'($urandom), {$urandom, $urandom},
          ($urandom_range(0, 7) == 0));
      a_valid = ($urandom_range(0, 2) != 0);
      step();
    end

    reset = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    repeat (4) step();
    @(negedge clock);
    chk("final_drained", d_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1);
  end

endmodule
